// File: rtl/banked_register_file.sv
// Multi-bank integer register file with combinational write-first read ports,
// a registered active-bank selector and a background bank-clear engine.
module banked_register_file #(
  parameter int DataWidth    = 32,
  parameter int NumRegs      = 32,
  parameter int NumBanks     = 4,
  parameter int NumReadPorts = 2,
  parameter int IndexWidth   = $clog2(NumRegs),
  parameter int BankWidth    = $clog2(NumBanks)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              writeEn,
  input  logic [IndexWidth-1:0]             writeAddr,
  input  logic [DataWidth-1:0]              writeData,
  input  logic [NumReadPorts*IndexWidth-1:0] readAddr,
  output logic [NumReadPorts*DataWidth-1:0]  readData,
  input  logic                              bankSwitchEn,
  input  logic [BankWidth-1:0]              bankSwitchSel,
  output logic [BankWidth-1:0]              activeBank,
  input  logic                              clearReq,
  input  logic [BankWidth-1:0]              clearBank,
  output logic                              clearBusy,
  output logic                              clearDone
);

  typedef enum logic [1:0] {stIdle, stClear, stDone} clearState_t;

  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

  clearState_t                 state, stateNext;
  logic [BankWidth-1:0]        clearTgt;
  logic [IndexWidth-1:0]       clearIdx;
  logic [DataWidth-1:0]        regs [NumBanks][NumRegs];

  function automatic logic indexValid(input logic [IndexWidth-1:0] idx);
    return int'(idx) < NumRegs;
  endfunction

  function automatic logic bankValid(input logic [BankWidth-1:0] bank);
    return int'(bank) < NumBanks;
  endfunction

  // NOTE: every register-like process uses non-blocking assignments so all
  // flops sample the same pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      activeBank <= '0;
    end else if (bankSwitchEn && bankValid(bankSwitchSel)) begin
      activeBank <= bankSwitchSel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= stIdle;
    else        state <= stateNext;
  end

  // NOTE: a combinational block assigns its outputs a default first so that
  // no path through it leaves a value unassigned and infers a latch.
  always_comb begin
    stateNext = state;
    unique case (state)
      stIdle:  if (clearReq && bankValid(clearBank)) stateNext = stClear;
      stClear: if (clearIdx == LastIdx) stateNext = stDone;
      stDone:  stateNext = stIdle;
      default: stateNext = stIdle;
    endcase
  end

  always_comb begin
    clearBusy = (state == stClear);
    clearDone = (state == stDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clearTgt <= '0;
      clearIdx <= '0;
    end else if (state == stIdle && stateNext == stClear) begin
      clearTgt <= clearBank;
      clearIdx <= IndexWidth'(1);
    end else if (state == stClear) begin
      clearIdx <= clearIdx + IndexWidth'(1);
    end
  end

  // NOTE: the storage array is reset because an asynchronous reset must zero
  // every architectural register; this forces flops rather than a RAM macro.
  // The normal write is issued after the clear so it wins on a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NumBanks; b++) begin
        for (int r = 0; r < NumRegs; r++) begin
          regs[b][r] <= '0;
        end
      end
    end else begin
      if (clearBusy) regs[clearTgt][clearIdx] <= '0;
      if (writeEn && writeAddr != '0 && indexValid(writeAddr)) begin
        regs[activeBank][writeAddr] <= writeData;
      end
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : gRead
    logic [IndexWidth-1:0] idx;
    logic [DataWidth-1:0]  portData;

    assign idx = readAddr[p*IndexWidth +: IndexWidth];

    always_comb begin
      if (idx == '0 || !indexValid(idx))  portData = '0;
      else if (writeEn && writeAddr == idx) portData = writeData;
      else                                 portData = regs[activeBank][idx];
    end

    assign readData[p*DataWidth +: DataWidth] = portData;
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed vector table plus hand-written clear-engine and reset sequences
// for the banked register file at its default parameters.
module tb_banked_register_file;

  localparam int DataWidth    = 32;
  localparam int NumRegs      = 32;
  localparam int NumBanks     = 4;
  localparam int NumReadPorts = 2;
  localparam int IndexWidth   = 5;
  localparam int BankWidth    = 2;

  typedef struct {
    logic                  we;
    logic [IndexWidth-1:0] wa;
    logic [DataWidth-1:0]  wd;
    logic [IndexWidth-1:0] ra0;
    logic [IndexWidth-1:0] ra1;
    logic                  sw;
    logic [BankWidth-1:0]  sel;
    logic [DataWidth-1:0]  exp0;
    logic [DataWidth-1:0]  exp1;
    logic [BankWidth-1:0]  expBank;
  } vec_t;

  logic                               clk;
  logic                               reset;
  logic                               writeEn;
  logic [IndexWidth-1:0]              writeAddr;
  logic [DataWidth-1:0]               writeData;
  logic [NumReadPorts*IndexWidth-1:0] readAddr;
  logic [NumReadPorts*DataWidth-1:0]  readData;
  logic                               bankSwitchEn;
  logic [BankWidth-1:0]               bankSwitchSel;
  logic [BankWidth-1:0]               activeBank;
  logic                               clearReq;
  logic [BankWidth-1:0]               clearBank;
  logic                               clearBusy;
  logic                               clearDone;

  logic [DataWidth-1:0] rd0, rd1;
  assign rd0 = readData[DataWidth-1:0];
  assign rd1 = readData[2*DataWidth-1:DataWidth];

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs [14];

  banked_register_file #(
    .DataWidth(DataWidth), .NumRegs(NumRegs), .NumBanks(NumBanks),
    .NumReadPorts(NumReadPorts)
  ) dut (
    .clk(clk), .reset(reset),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr(readAddr), .readData(readData),
    .bankSwitchEn(bankSwitchEn), .bankSwitchSel(bankSwitchSel), .activeBank(activeBank),
    .clearReq(clearReq), .clearBank(clearBank),
    .clearBusy(clearBusy), .clearDone(clearDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DataWidth-1:0] act,
                       input logic [DataWidth-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [IndexWidth-1:0] wa,
      input logic [DataWidth-1:0] wd, input logic [IndexWidth-1:0] ra0,
      input logic [IndexWidth-1:0] ra1, input logic sw, input logic [BankWidth-1:0] sel,
      input logic [DataWidth-1:0] exp0, input logic [DataWidth-1:0] exp1,
      input logic [BankWidth-1:0] expBank);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.sw = sw; v.sel = sel; v.exp0 = exp0; v.exp1 = exp1; v.expBank = expBank;
    return v;
  endfunction

  task automatic driveIdle();
    writeEn = 1'b0; writeAddr = '0; writeData = '0;
    bankSwitchEn = 1'b0; bankSwitchSel = '0;
    clearReq = 1'b0; clearBank = '0;
  endtask

  task automatic setRead(input logic [IndexWidth-1:0] a0, input logic [IndexWidth-1:0] a1);
    readAddr = {a1, a0};
  endtask

  // Switch the active bank; returns at the negedge after the switch edge.
  task automatic switchBank(input logic [BankWidth-1:0] b);
    @(negedge clk);
    driveIdle();
    bankSwitchEn = 1'b1; bankSwitchSel = b;
    @(negedge clk);
    driveIdle();
  endtask

  task automatic writeReg(input logic [IndexWidth-1:0] a, input logic [DataWidth-1:0] d);
    @(negedge clk);
    driveIdle();
    writeEn = 1'b1; writeAddr = a; writeData = d;
  endtask

  initial begin
    logic [DataWidth-1:0] orAcc;
    int busyCycles;
    logic seenDone;
    logic busyAll;

    reset = 1'b0;
    driveIdle();
    setRead(5'd0, 5'd1);
    repeat (2) @(negedge clk);
    check("reset.activeBank", 32'(activeBank), 32'd0);
    check("reset.clearBusy", 32'(clearBusy), 32'd0);
    check("reset.clearDone", 32'(clearDone), 32'd0);
    reset = 1'b1;

    vecs[0]  = mk(0, 0,  32'h0,        0,  1,  0, 0, 32'h0,        32'h0,        0);
    vecs[1]  = mk(1, 1,  32'h12345678, 0,  1,  0, 0, 32'h0,        32'h12345678, 0);
    vecs[2]  = mk(0, 0,  32'h0,        0,  1,  0, 0, 32'h0,        32'h12345678, 0);
    vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0,  0,  0, 0, 32'h0,        32'h0,        0);
    vecs[4]  = mk(0, 0,  32'h0,        0,  1,  0, 0, 32'h0,        32'h12345678, 0);
    vecs[5]  = mk(1, 31, 32'hDEADBEEF, 31, 1,  0, 0, 32'hDEADBEEF, 32'h12345678, 0);
    vecs[6]  = mk(0, 0,  32'h0,        31, 1,  1, 1, 32'hDEADBEEF, 32'h12345678, 0);
    vecs[7]  = mk(0, 0,  32'h0,        31, 1,  0, 0, 32'h0,        32'h0,        1);
    vecs[8]  = mk(0, 0,  32'h0,        31, 1,  1, 0, 32'h0,        32'h0,        1);
    vecs[9]  = mk(0, 0,  32'h0,        31, 1,  0, 0, 32'hDEADBEEF, 32'h12345678, 0);
    vecs[10] = mk(1, 5,  32'hA5A5A5A5, 5,  31, 1, 2, 32'hA5A5A5A5, 32'hDEADBEEF, 0);
    vecs[11] = mk(0, 0,  32'h0,        5,  31, 0, 0, 32'h0,        32'h0,        2);
    vecs[12] = mk(0, 0,  32'h0,        5,  31, 1, 0, 32'h0,        32'h0,        2);
    vecs[13] = mk(0, 0,  32'h0,        5,  31, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      writeEn = vecs[i].we; writeAddr = vecs[i].wa; writeData = vecs[i].wd;
      bankSwitchEn = vecs[i].sw; bankSwitchSel = vecs[i].sel;
      setRead(vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("vec%0d.rd0", i), rd0, vecs[i].exp0);
      check($sformatf("vec%0d.rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d.bank", i), 32'(activeBank), 32'(vecs[i].expBank));
    end

    // Fill bank 1, then clear it and time the engine.
    switchBank(2'd1);
    for (int i = 1; i < NumRegs; i++) writeReg(5'(i), 32'h100 + 32'(i));
    @(negedge clk);
    driveIdle();
    setRead(5'd7, 5'd31);
    #1;
    check("fill.x7", rd0, 32'h107);
    check("fill.x31", rd1, 32'h11F);

    clearReq = 1'b1; clearBank = 2'd1;
    @(negedge clk);
    driveIdle();
    busyCycles = 0;
    seenDone = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (clearDone) begin
        seenDone = 1'b1;
        break;
      end
      if (clearBusy) busyCycles++;
      @(negedge clk);
    end
    check("clear1.doneSeen", 32'(seenDone), 32'd1);
    check("clear1.busyCycles", 32'(busyCycles), 32'd31);
    check("clear1.busyAtDone", 32'(clearBusy), 32'd0);
    @(negedge clk);
    check("clear1.donePulse", 32'(clearDone), 32'd0);
    orAcc = '0;
    for (int i = 1; i < NumRegs; i++) begin
      setRead(5'(i), 5'(i));
      #1;
      orAcc = orAcc | rd0;
    end
    check("clear1.bank1Zero", orAcc, 32'h0);

    switchBank(2'd0);
    setRead(5'd1, 5'd31);
    #1;
    check("clear1.bank0x1", rd0, 32'h12345678);
    check("clear1.bank0x31", rd1, 32'hDEADBEEF);

    // Collision between a normal write and the engine at index 20.
    switchBank(2'd1);
    writeReg(5'd10, 32'h77);
    writeReg(5'd20, 32'h55);
    @(negedge clk);
    driveIdle();
    clearReq = 1'b1; clearBank = 2'd1;
    busyAll = 1'b1;
    for (int k = 1; k < NumRegs; k++) begin
      @(negedge clk);
      driveIdle();
      busyAll = busyAll & clearBusy;
      if (k == 5) begin
        clearReq = 1'b1; clearBank = 2'd0;
      end
      if (k == 15) begin
        setRead(5'd10, 5'd20);
        #1;
        check("clear2.partialX10", rd0, 32'h0);
        check("clear2.partialX20", rd1, 32'h55);
      end
      if (k == 20) begin
        writeEn = 1'b1; writeAddr = 5'd20; writeData = 32'hCAFEF00D;
      end
    end
    @(negedge clk);
    driveIdle();
    check("clear2.busyThroughout", 32'(busyAll), 32'd1);
    check("clear2.done", 32'(clearDone), 32'd1);
    check("clear2.busyAtDone", 32'(clearBusy), 32'd0);
    @(negedge clk);
    check("clear2.doneOnce", 32'(clearDone), 32'd0);
    setRead(5'd10, 5'd20);
    #1;
    check("clear2.x10", rd0, 32'h0);
    check("clear2.x20", rd1, 32'hCAFEF00D);
    switchBank(2'd0);
    setRead(5'd1, 5'd5);
    #1;
    check("clear2.bank0x1", rd0, 32'h12345678);
    check("clear2.bank0x5", rd1, 32'hA5A5A5A5);

    // Asynchronous reset in the middle of a clear.
    switchBank(2'd1);
    setRead(5'd1, 5'd31);
    clearReq = 1'b1; clearBank = 2'd2;
    @(negedge clk);
    driveIdle();
    repeat (4) @(negedge clk);
    check("rstMid.busyBefore", 32'(clearBusy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstMid.busy", 32'(clearBusy), 32'd0);
    check("rstMid.done", 32'(clearDone), 32'd0);
    check("rstMid.bank", 32'(activeBank), 32'd0);
    check("rstMid.x1", rd0, 32'h0);
    check("rstMid.x31", rd1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    busyAll = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      busyAll = busyAll | clearBusy | clearDone;
    end
    check("rstMid.engineIdle", 32'(busyAll), 32'd0);
    switchBank(2'd1);
    setRead(5'd20, 5'd31);
    #1;
    check("rstMid.bank1x20", rd0, 32'h0);
    check("rstMid.bank1x31", rd1, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
- Parametrised successor to the core integer register file, giving the core multiple register banks for fast interrupt context switching.
- Provides NumReadPorts combinational read ports and one synchronous write port, all on the currently active bank.
- Adds a registered bank selector and a background bank-clear engine, so a bank can be zeroed before it is reused by a new handler.
- Sits in the decode/writeback path of the core, in place of the single-bank file.

Parameters:
- DataWidth, 32: width of each register.
- NumRegs, 32: registers per bank; index 0 is hardwired zero.
- NumBanks, 4: number of register banks; must be >= 2.
- NumReadPorts, 2: number of independent read ports.
- IndexWidth, $clog2(NumRegs): register index width (derived).
- BankWidth, $clog2(NumBanks): bank index width (derived).

Ports:
- clk  in  1  clock; rising-edge active.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- writeEn  in  1  write strobe for the active bank.
- writeAddr  in  IndexWidth  write register index.
- writeData  in  DataWidth  write data.
- readAddr  in  NumReadPorts*IndexWidth  packed read indices; port p uses slice p.
- readData  out  NumReadPorts*DataWidth  packed read data; port p uses slice p.
- bankSwitchEn  in  1  request to change the active bank.
- bankSwitchSel  in  BankWidth  target bank for the switch.
- activeBank  out  BankWidth  registered current bank.
- clearReq  in  1  request to zero a bank.
- clearBank  in  BankWidth  bank to zero; sampled when the request is accepted.
- clearBusy  out  1  high while the clear engine runs.
- clearDone  out  1  one-cycle pulse when a clear completes.

Behaviour:
Reset (reset=0, asynchronous):
- All registers in all banks = 0.
- activeBank = 0; clear FSM = IDLE; clearBusy = 0; clearDone = 0.
- Deassertion is sampled at the next clock edge.
- Reset mid-clear aborts the clear.

Reads (combinational):
- readData[p] = bank[activeBank][readAddr[p]].
- Write-first bypass: if writeEn=1, writeAddr==readAddr[p] and writeAddr!=0, then readData[p] = writeData in the same cycle.
- Index 0 always reads 0.
- Read-index bits beyond NumRegs-1 are don't-care when NumRegs is not a power of 2; reads of such indices return 0.

Writes:
- On a rising edge with writeEn=1 and writeAddr!=0: bank[activeBank][writeAddr] <= writeData.
- Writes to index 0 are ignored.

Bank switch:
- On a rising edge with bankSwitchEn=1: activeBank <= bankSwitchSel.
- A write in the same cycle targets the old activeBank.
- Reads see the new bank from the following cycle.
- bankSwitchSel >= NumBanks is ignored; activeBank is held.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE: when clearReq=1 and clearBank < NumBanks, latch tgt=clearBank, set idx=1, go to CLEAR, set clearBusy=1. In all other cases clearReq is ignored.
- CLEAR: each cycle, bank[tgt][idx] <= 0 and idx++. After writing idx=NumRegs-1, go to DONE. Takes exactly NumRegs-1 cycles.
- DONE: clearBusy=0, clearDone=1 for one cycle, then IDLE.
- clearReq in CLEAR or DONE is ignored; there is no queuing.
- Same-cycle collision (normal write and clear hit the same bank and index): the normal write wins and its data persists.
- Reads of tgt during CLEAR return the partially cleared contents.
- Bank switching is permitted during a clear, including to or from tgt.
- Latency: clearReq accepted at edge N gives clearBusy=1 after N, clearDone=1 after edge N+NumRegs-1, and clearBusy=0 from that same edge.

Test Plan:
- Reset, then write x1=0x12345678 in bank 0 with readAddr={0,1} -> same cycle readData={0,0x12345678}; next cycle unchanged; write x0=0xFFFFFFFF -> x0 reads 0.
- Write x31=0xDEADBEEF in bank 0, switch to bank 1 -> activeBank=1 next cycle; x31 reads 0; switch back to 0 -> x31 reads 0xDEADBEEF.
- Assert bankSwitchEn=1 (sel=2) and writeEn=1 (x5=0xA5A5A5A5) in the same cycle -> value lands in bank 0 (not 2); bank 2 x5 reads 0.
- Fill bank 1 x1..x31 with 0x100+i, clearReq with clearBank=1 -> clearBusy high 31 cycles; clearDone pulses once; all bank-1 regs read 0; bank 0 untouched.
- During a bank-1 clear with activeBank=1, write x20=0xCAFEF00D in the same cycle the engine clears idx 20 -> x20 reads 0xCAFEF00D after done; second clearReq while busy -> ignored.
- Drive reset=0 asynchronously mid-clear (between edges) -> clearBusy=0, activeBank=0 and all registers 0 immediately, before the next edge.
